pwm_i2c_reg_bridge: RTL



---
 rtl/pwm_i2c_reg_bridge_if.sv | 42 ++++
 rtl/pwm_i2c_reg_bridge.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_i2c_reg_bridge_if.sv
// pwm_i2c_reg_bridge_if
// Bundles the signals between the I2C byte engine, the bridge and the PWM
// register file.
//   master modport : the bridge side (consumes I2C byte events, drives the
//                    register bus and the transmit byte)
//   slave modport  : the environment side (byte engine + register file)
// Signals:
//   start_i/stop_i      1-cycle START / STOP pulses
//   rx_valid_i/rx_data_i received byte strobe and data
//   tx_req_i            master asks for the next read byte
//   tx_data_o/tx_valid_o byte to transmit and its 1-cycle valid
//   wr_en_o/rd_en_o     register write / read strobes
//   addr_o              register address
//   wr_data_o/rd_data_i register write data / combinational read data
//   busy_o              bridge is inside a transaction
interface pwm_i2c_reg_bridge_if #(
  parameter int WIDTH = 16
);
  logic             start_i;
  logic             stop_i;
  logic             rx_valid_i;
  logic [7:0]       rx_data_i;
  logic             tx_req_i;
  logic [7:0]       tx_data_o;
  logic             tx_valid_o;
  logic             wr_en_o;
  logic             rd_en_o;
  logic [7:0]       addr_o;
  logic [WIDTH-1:0] wr_data_o;
  logic [WIDTH-1:0] rd_data_i;
  logic             busy_o;

  modport master (
    input  start_i, stop_i, rx_valid_i, rx_data_i, tx_req_i, rd_data_i,
    output tx_data_o, tx_valid_o, wr_en_o, rd_en_o, addr_o, wr_data_o, busy_o
  );

  modport slave (
    output start_i, stop_i, rx_valid_i, rx_data_i, tx_req_i, rd_data_i,
    input  tx_data_o, tx_valid_o, wr_en_o, rd_en_o, addr_o, wr_data_o, busy_o
  );
endinterface

// File: rtl/pwm_i2c_reg_bridge.sv
// pwm_i2c_reg_bridge
// Converts the byte stream of an I2C slave front end into 16-bit register
// transactions on the PWM register block. After START the first byte is the
// register address; each following high/low byte pair is one register write.
// Read requests return the register at the current address, high byte first.
// Ports:
//   clk_psc_i  system clock
//   rst_n_i    asynchronous active-low reset
//   bus        pwm_i2c_reg_bridge_if.master (byte events in, register bus out)
// Parameters:
//   WIDTH      register data width, only 16 is meaningful (two bytes)
//   ADDR_MAX   highest valid register address, auto-increment wrap point
// Configuration macro:
//   BRIDGE_AUTOINC_EN  when defined, the address advances after every
//                      completed write or two-byte read; when undefined the
//                      address only changes on an address byte.
module pwm_i2c_reg_bridge #(
  parameter int WIDTH    = 16,
  parameter int ADDR_MAX = 41
) (
  input logic                    clk_psc_i,
  input logic                    rst_n_i,
  pwm_i2c_reg_bridge_if.master   bus
);

  localparam logic [7:0] ADDR_MAX_B = 8'(ADDR_MAX);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WR_HI,
    WR_LO,
    RD_LO
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [7:0]       addr_q;
  logic [7:0]       hi_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] wr_data_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic             wr_en_q;
  logic             rd_en_q;

  logic             ev_rx;
  logic             ev_tx;
  logic             load_addr;
  logic             load_hi;
  logic             do_write;
  logic             do_read;
  logic             do_tx_lo;
  logic             addr_adv;
  logic [7:0]       addr_next;

  // Only one event acts per cycle: START beats STOP beats a received byte
  // beats a transmit request; the losers are simply dropped.
  assign ev_rx = !bus.start_i && !bus.stop_i && bus.rx_valid_i;
  assign ev_tx = !bus.start_i && !bus.stop_i && !bus.rx_valid_i && bus.tx_req_i;

  // Out-of-range addresses also wrap to 0 on the next advance.
  assign addr_next = (addr_q >= ADDR_MAX_B) ? 8'd0 : addr_q + 8'd1;

  // The address moves on once a write strobe has been presented, or when the
  // low read byte goes out.
`ifdef BRIDGE_AUTOINC_EN
  assign addr_adv = wr_en_q || do_tx_lo;
`else
  assign addr_adv = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and action decode. START/STOP override whatever the current
  // state decided, which is how half-built transactions get discarded.
  // In RD_LO a request is ignored while the read strobe is still out, since
  // the high byte has not been delivered yet.
  always_comb begin
    state_d   = state_q;
    load_addr = 1'b0;
    load_hi   = 1'b0;
    do_write  = 1'b0;
    do_read   = 1'b0;
    do_tx_lo  = 1'b0;
    case (state_q)
      IDLE: begin
      end
      ADDR: begin
        if (ev_rx) begin
          load_addr = 1'b1;
          state_d   = WR_HI;
        end else if (ev_tx) begin
          do_read = 1'b1;
          state_d = RD_LO;
        end
      end
      WR_HI: begin
        if (ev_rx) begin
          load_hi = 1'b1;
          state_d = WR_LO;
        end else if (ev_tx) begin
          do_read = 1'b1;
          state_d = RD_LO;
        end
      end
      WR_LO: begin
        if (ev_rx) begin
          do_write = 1'b1;
          state_d  = WR_HI;
        end
      end
      RD_LO: begin
        if (ev_tx && !rd_en_q) begin
          do_tx_lo = 1'b1;
          state_d  = WR_HI;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.start_i) begin
      state_d = ADDR;
    end else if (bus.stop_i) begin
      state_d = IDLE;
    end
  end

  // Datapath and registered outputs. The read strobe cycle captures the
  // register value and, unless START/STOP arrives in that same cycle, sends
  // its high byte on the following cycle.
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q     <= '0;
      hi_q       <= '0;
      shadow_q   <= '0;
      wr_data_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      wr_en_q    <= do_write;
      rd_en_q    <= do_read;
      tx_valid_q <= 1'b0;
      if (load_hi) begin
        hi_q <= bus.rx_data_i;
      end
      if (do_write) begin
        wr_data_q <= {hi_q, bus.rx_data_i};
      end
      if (rd_en_q) begin
        shadow_q <= bus.rd_data_i;
        if (!bus.start_i && !bus.stop_i) begin
          tx_valid_q <= 1'b1;
          tx_data_q  <= bus.rd_data_i[WIDTH-1:WIDTH-8];
        end
      end
      if (do_tx_lo) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= shadow_q[7:0];
      end
      if (load_addr) begin
        addr_q <= bus.rx_data_i;
      end else if (addr_adv) begin
        addr_q <= addr_next;
      end
    end
  end

  assign bus.addr_o     = addr_q;
  assign bus.wr_en_o    = wr_en_q;
  assign bus.rd_en_o    = rd_en_q;
  assign bus.wr_data_o  = wr_data_q;
  assign bus.tx_data_o  = tx_data_q;
  assign bus.tx_valid_o = tx_valid_q;
  assign bus.busy_o     = (state_q != IDLE);

endmodule
